// File: rtl/gauss_sep_pipe.sv
// Separable binomial KxK Gaussian over one event window: row sums, column sum,
// optional rounding normalisation, then a credit-protected output FIFO.

package gauss_sep_pkg;
  function automatic int unsigned binom(input int k, input int i);
    if (k == 3) return (i == 1) ? 2 : 1;
    case (i)
      0, 4:    return 1;
      1, 3:    return 4;
      default: return 6;
    endcase
  endfunction
endpackage

// One window row weighted by the 1D binomial taps; purely combinational.
module gauss_sep_row #(
  parameter int DW = 14,
  parameter int K  = 3
) (
  input  logic [K-1:0][DW-1:0] pix,
  output logic [DW+K-2:0]      sum
);
  localparam int RW = DW + K - 1;

  always_comb begin
    sum = '0;
    for (int c = 0; c < K; c++)
      sum = sum + RW'(gauss_sep_pkg::binom(K, c)) * RW'(pix[c]);
  end
endmodule

module gauss_sep_pipe #(
  parameter int DATA_WIDTH = 14,
  parameter int KSIZE      = 3,
  parameter int NORMALIZE  = 0,
  parameter int ADDR_WIDTH = 16,
  parameter int OUT_DEPTH  = 4,
  localparam int S  = 2 * (KSIZE - 1),
  localparam int OW = (NORMALIZE != 0) ? DATA_WIDTH : DATA_WIDTH + S
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [DATA_WIDTH*KSIZE*KSIZE-1:0]     in_window_value,
  input  logic                                  in_window_valid,
  input  logic [ADDR_WIDTH-1:0]                 in_window_addr,
  output logic                                  window_req,
  output logic [OW-1:0]                         out_event_value,
  output logic                                  out_event_valid,
  output logic [ADDR_WIDTH-1:0]                 out_event_addr,
  input  logic                                  ready_for_new_event
);
  localparam int RW     = DATA_WIDTH + KSIZE - 1;
  localparam int SW     = DATA_WIDTH + S;
  localparam int PW     = $clog2(OUT_DEPTH);
  localparam int CW     = PW + 2;
  localparam int EW     = OW + ADDR_WIDTH;
  localparam int STAGES = 3;

  if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
    $error("gauss_sep_pipe: KSIZE must be 3 or 5");
  end
  if (OUT_DEPTH < 4 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("gauss_sep_pipe: OUT_DEPTH must be a power of two >= 4");
  end

  logic [STAGES:1]                         vld_pipe;
  logic [KSIZE-1:0][KSIZE-1:0][DATA_WIDTH-1:0] win;
  logic [KSIZE-1:0][RW-1:0]                row_sum, s1_row;
  logic [SW-1:0]                           col_sum, s2_sum;
  logic [OW-1:0]                           s3_d, s3_val;
  logic [ADDR_WIDTH-1:0]                   a1, a2, a3;
  logic                                    accept, push, pop;
  logic [CW-1:0]                           credit;
  logic [PW-1:0]                           wptr, rptr;
  logic [PW:0]                             count;
  logic [EW-1:0]                           mem [OUT_DEPTH];
  logic [EW-1:0]                           head;

  // Row r of the window lives at DW*K*r, column c at DW*c within the row.
  assign win = in_window_value;

  for (genvar r = 0; r < KSIZE; r++) begin : g_row
    gauss_sep_row #(.DW(DATA_WIDTH), .K(KSIZE)) u_row (
      .pix (win[r]),
      .sum (row_sum[r])
    );
  end

  always_comb begin
    col_sum = '0;
    for (int r = 0; r < KSIZE; r++)
      col_sum = col_sum + SW'(gauss_sep_pkg::binom(KSIZE, r)) * SW'(s1_row[r]);
  end

  // Rounding add never carries out: max sum + half LSB stays below 2^SW.
  if (NORMALIZE != 0) begin : g_norm
    logic [SW-1:0] rounded;
    assign rounded = s2_sum + SW'(2 ** (S - 1));
    assign s3_d    = rounded[SW-1:S];
  end else begin : g_raw
    assign s3_d = s2_sum;
  end

  // Credit counts every event that could still land in the FIFO, so a full
  // FIFO can never be pushed regardless of what the scheduler does.
  assign credit     = CW'(count) + CW'(vld_pipe[1]) + CW'(vld_pipe[2]) + CW'(vld_pipe[3]);
  assign window_req = credit < CW'(OUT_DEPTH);
  assign accept     = in_window_valid && window_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_row   <= '0;
      s2_sum   <= '0;
      s3_val   <= '0;
      a1       <= '0;
      a2       <= '0;
      a3       <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], accept};
      if (accept) begin
        s1_row <= row_sum;
        a1     <= in_window_addr;
      end
      if (vld_pipe[1]) begin
        s2_sum <= col_sum;
        a2     <= a1;
      end
      if (vld_pipe[2]) begin
        s3_val <= s3_d;
        a3     <= a2;
      end
    end
  end

  assign push = vld_pipe[3];
  assign pop  = out_event_valid && ready_for_new_event;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {s3_val, a3};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; gating by valid keeps outputs clean after reset.
  assign head            = mem[rptr];
  assign out_event_valid = (count != '0);
  assign out_event_value = out_event_valid ? head[EW-1:ADDR_WIDTH] : '0;
  assign out_event_addr  = out_event_valid ? head[ADDR_WIDTH-1:0]  : '0;

endmodule
